ram_dp_arbiter: RTL
===================

# ram_dp_arbiter

Arbiter/scheduler that shares one `ram_dp` dual-port memory between three FFT-side requesters: a sample/result writer, a port-1 reader and a port-2 reader. It issues per-cycle grants so that no forbidden access combination ever reaches the RAM: write with read1 on the shared port, or write with read2 at the same address. It also returns read data with a valid strobe. It sits between the FFT control/butterfly logic and the RAM instance.

## Interface
Parameters:
- `M`, 8, address width
- `Nb`, 16, data width

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `wr_req`  in  1  writer requests a write
- `wr_addr`  in  M  write address
- `wr_data`  in  Nb  write data
- `wr_grant`  out  1  write performed this cycle
- `rd1_req`  in  1  port-1 reader requests a read
- `rd1_addr`  in  M  port-1 read address
- `rd1_grant`  out  1  read1 issued this cycle
- `rd1_valid`  out  1  `rd1_data` valid, one cycle after `rd1_grant`
- `rd1_data`  out  Nb  read1 result
- `rd2_req`  in  1  port-2 reader requests a read
- `rd2_addr`  in  M  port-2 read address
- `rd2_grant`  out  1  read2 issued this cycle
- `rd2_valid`  out  1  `rd2_data` valid, one cycle after `rd2_grant`
- `rd2_data`  out  Nb  read2 result
- `ram_rw_addr`, `ram_write_enable`, `ram_write_data`, `ram_read1_enable`  out  M/1/Nb/1  to RAM port 1
- `ram_read2_addr`, `ram_read2_enable`  out  M/1  to RAM port 2
- `ram_read1_data`, `ram_read2_data`  in  Nb  from RAM
- `conflict_count`  out  16  saturating count of cycles in which any request was denied

## Operation
- Handshake: the requester holds req/addr/data stable until it sees its grant. The grant is combinational, in the same cycle, from req and registered arbiter state. The transfer happens in the grant cycle. Req may drop only after the grant.
- Port 1 is shared by writer and rd1. Only one is granted per cycle, using 2-way round-robin.
  - State `PRI_WR` (reset) or `PRI_RD1` holds the current priority.
  - If both request, the priority holder wins. State then flips to favour the loser.
  - If only one requests, it is granted and the state is unchanged.
- Port 2: `rd2_grant = rd2_req && !(wr_grant && wr_addr == rd2_addr)`. A same-address write always wins; rd2 retries next cycle.
- RAM drive:
  - `ram_write_enable = wr_grant`
  - `ram_read1_enable = rd1_grant`
  - `ram_rw_addr` = `wr_addr` if `wr_grant`, else `rd1_addr`
  - `ram_write_data = wr_data`
  - `ram_read2_enable = rd2_grant`
  - `ram_read2_addr = rd2_addr`
- Read return: `rd1_valid`/`rd2_valid` are registered copies of the grants. `rd1_data`/`rd2_data` pass through directly from the RAM outputs and are meaningful only while valid is high.
- `conflict_count` increments by 1 in any cycle where at least one asserted req gets no grant. It saturates at 16'hFFFF.
- Invariant, checked by assertion: never `ram_write_enable && ram_read1_enable`; never `ram_write_enable && ram_read2_enable && ram_rw_addr == ram_read2_addr`.

## Timing
- Grant latency: 0 cycles (combinational). Read data latency: 1 cycle after grant.
- Reset values:
  - all grants 0
  - all `ram_*_enable` 0
  - `rd1_valid`/`rd2_valid` 0
  - arbiter state `PRI_WR`
  - `conflict_count` 0
- Addresses and write data pass through unregistered.
- While `reset` is high, grants and RAM enables are forced to 0 regardless of req. Reset mid-read drops the pending valid; the next cycle shows valid 0.
- Back-to-back: a requester holding req continuously while uncontested is granted every cycle, giving 1 access per cycle.
- Worst-case wait under continuous contention:
  - wr and rd1: 1 cycle (alternating grants)
  - rd2: unbounded only while the writer keeps hitting the same address

## Structure
- Package `fft_mem_pkg`:
  - default `M`/`Nb`
  - enum `pri_t {PRI_WR, PRI_RD1}`
  - `CONFLICT_MAX` constant
- Sub-module `rr_arb2`: 2-requester round-robin with registered priority bit, used for port 1. Port-2 hazard logic, valid pipeline and counter stay in the top.
- Verification instantiates the existing dual-port RAM behind the arbiter. Any RAM collision message fails the test.

## Test plan
- Reset, then wr only, addr 0x10..0x13, data 0xA000..0xA003 → `wr_grant` high 4 consecutive cycles; `conflict_count` stays 0.
- Writes complete; rd1 reads 0x10..0x13 → `rd1_valid` one cycle after each grant, data 0xA000..0xA003.
- wr (addr 0x20) and rd1 (addr 0x21) both held 4 cycles from reset → grants alternate wr, rd1, wr, rd1; `conflict_count` = 4.
- wr addr 0x30 and rd2 addr 0x30 same cycle → `wr_grant` 1, `rd2_grant` 0. Next cycle (wr idle) `rd2_grant` 1, then `rd2_data` = written value.
- wr 0x40 and rd2 0x41 same cycle → both granted; rd2 returns the old contents of 0x41; no conflict counted.
- rd1 granted, `reset` asserted the next cycle → `rd1_valid` 0, all enables 0, state `PRI_WR`, `conflict_count` 0.

Source files
------------

// File: rtl/fft_mem_pkg.sv
// Shared types and constants for the FFT memory arbiter slice.
package fft_mem_pkg;

  localparam int M_DEFAULT  = 8;
  localparam int NB_DEFAULT = 16;

  localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

  typedef enum logic {
    PRI_WR  = 1'b0,
    PRI_RD1 = 1'b1
  } pri_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; requester A is the writer, B the port-1 reader.
//
// state   | meaning
// PRI_WR  | writer wins the next contended cycle
// PRI_RD1 | port-1 reader wins the next contended cycle
module rr_arb2
  import fft_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_grant_a,
  output logic o_grant_b
);

  pri_t r_pri;
  pri_t w_pri_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_pri <= PRI_WR;
    else       r_pri <= w_pri_nxt;
  end

  always_comb begin
    o_grant_a = 1'b0;
    o_grant_b = 1'b0;
    w_pri_nxt = r_pri;
    if (!reset) begin
      if (i_req_a && i_req_b) begin
        // Priority passes to the loser so neither side waits more than one cycle.
        if (r_pri == PRI_WR) begin
          o_grant_a = 1'b1;
          w_pri_nxt = PRI_RD1;
        end else begin
          o_grant_b = 1'b1;
          w_pri_nxt = PRI_WR;
        end
      end else begin
        o_grant_a = i_req_a;
        o_grant_b = i_req_b;
      end
    end
  end

endmodule

// File: rtl/ram_dp_arbiter.sv
// Shares one dual-port RAM between the FFT writer and two readers, keeping
// forbidden port combinations away from the RAM and returning read data with a valid strobe.
module ram_dp_arbiter
  import fft_mem_pkg::*;
#(
  parameter int M  = M_DEFAULT,
  parameter int Nb = NB_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [M-1:0]  wr_addr,
  input  logic [Nb-1:0] wr_data,
  output logic          wr_grant,
  input  logic          rd1_req,
  input  logic [M-1:0]  rd1_addr,
  output logic          rd1_grant,
  output logic          rd1_valid,
  output logic [Nb-1:0] rd1_data,
  input  logic          rd2_req,
  input  logic [M-1:0]  rd2_addr,
  output logic          rd2_grant,
  output logic          rd2_valid,
  output logic [Nb-1:0] rd2_data,
  output logic [M-1:0]  ram_rw_addr,
  output logic          ram_write_enable,
  output logic [Nb-1:0] ram_write_data,
  output logic          ram_read1_enable,
  output logic [M-1:0]  ram_read2_addr,
  output logic          ram_read2_enable,
  input  logic [Nb-1:0] ram_read1_data,
  input  logic [Nb-1:0] ram_read2_data,
  output logic [15:0]   conflict_count
);

  logic        w_wr_grant;
  logic        w_rd1_grant;
  logic        w_rd2_grant;
  logic        w_deny;
  logic        r_rd1_valid;
  logic        r_rd2_valid;
  logic [15:0] r_conflict_count;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req_a   (wr_req),
    .i_req_b   (rd1_req),
    .o_grant_a (w_wr_grant),
    .o_grant_b (w_rd1_grant)
  );

  // A same-address write always beats port 2; the reader retries next cycle.
  assign w_rd2_grant = !reset && rd2_req && !(w_wr_grant && (wr_addr == rd2_addr));

  assign w_deny = (wr_req  && !w_wr_grant)  ||
                  (rd1_req && !w_rd1_grant) ||
                  (rd2_req && !w_rd2_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd1_valid      <= 1'b0;
      r_rd2_valid      <= 1'b0;
      r_conflict_count <= 16'd0;
    end else begin
      r_rd1_valid <= w_rd1_grant;
      r_rd2_valid <= w_rd2_grant;
      if (w_deny && (r_conflict_count != CONFLICT_MAX))
        r_conflict_count <= r_conflict_count + 16'd1;
    end
  end

  assign wr_grant         = w_wr_grant;
  assign rd1_grant        = w_rd1_grant;
  assign rd2_grant        = w_rd2_grant;
  assign rd1_valid        = r_rd1_valid;
  assign rd2_valid        = r_rd2_valid;
  assign rd1_data         = ram_read1_data;
  assign rd2_data         = ram_read2_data;
  assign conflict_count   = r_conflict_count;

  assign ram_write_enable = w_wr_grant;
  assign ram_read1_enable = w_rd1_grant;
  assign ram_rw_addr      = w_wr_grant ? wr_addr : rd1_addr;
  assign ram_write_data   = wr_data;
  assign ram_read2_enable = w_rd2_grant;
  assign ram_read2_addr   = rd2_addr;

endmodule
